// File: rtl/alu_sched.sv
// -----------------------------------------------------------------------------
// alu_sched
//
// Two-requester scheduler in front of the shared 32-bit ALU. Requests arrive on
// valid/ready handshakes and are granted round-robin. The granted request's
// mode and operands are registered onto the ALU inputs. The scheduler waits
// for the operation's latency and then returns the ALU answer to the owning
// requester with a one-cycle response pulse.
//
// Multiply modes (mode == 7'b0000110, or mode[6:2] == 5'b01010) take MUL_LAT
// cycles because the ALU multiplier is pipelined. Every other mode takes one
// cycle.
//
// Parameters
//   MUL_LAT    : multiply latency in cycles (>= 1)
//
// Ports
//   clk, rst                 : clock, asynchronous active-high reset
//   reqN_valid / reqN_ready  : request handshake for requester N (0 or 1)
//   reqN_mode, reqN_arg0/1   : operation sampled at the handshake edge
//   rspN_valid               : one-cycle pulse when requester N's result lands
//   rspN_data                : result; held until the next response to N
//   alu_mode, alu_arg0/1     : registered drive to the ALU
//   alu_ans                  : ALU result
//   busy                     : high while an operation is in flight
// -----------------------------------------------------------------------------
module alu_sched #(
    parameter int MUL_LAT = 2
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [6:0]  req0_mode,
    input  logic [31:0] req0_arg0,
    input  logic [31:0] req0_arg1,
    output logic        rsp0_valid,
    output logic [31:0] rsp0_data,

    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [6:0]  req1_mode,
    input  logic [31:0] req1_arg0,
    input  logic [31:0] req1_arg1,
    output logic        rsp1_valid,
    output logic [31:0] rsp1_data,

    output logic [6:0]  alu_mode,
    output logic [31:0] alu_arg0,
    output logic [31:0] alu_arg1,
    input  logic [31:0] alu_ans,
    output logic        busy
);

    // The counter only ever holds values 0 .. MUL_LAT-1.
    localparam int               CNT_W        = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
    localparam logic [CNT_W-1:0] MUL_CNT_LOAD = CNT_W'(MUL_LAT - 1);

    typedef enum logic {
        IDLE = 1'b0,
        EXEC = 1'b1
    } state_t;

    // -------------------------------------------------------------------------
    // Requester-indexed views of the ports, so that the per-requester logic
    // can be generated.
    // -------------------------------------------------------------------------
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [6:0]  req_mode [2];
    logic [31:0] req_arg0 [2];
    logic [31:0] req_arg1 [2];

    assign req_valid   = {req1_valid, req0_valid};
    assign req_mode[0] = req0_mode;
    assign req_mode[1] = req1_mode;
    assign req_arg0[0] = req0_arg0;
    assign req_arg0[1] = req1_arg0;
    assign req_arg1[0] = req0_arg1;
    assign req_arg1[1] = req1_arg1;
    assign req0_ready  = req_ready[0];
    assign req1_ready  = req_ready[1];

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_t           state_reg;
    logic             pri_reg;       // requester that wins when both are valid
    logic             owner_reg;     // requester whose operation is in flight
    logic [CNT_W-1:0] cnt_reg;       // remaining EXEC cycles after this one
    logic             busy_reg;
    logic [6:0]       alu_mode_reg;
    logic [31:0]      alu_arg0_reg;
    logic [31:0]      alu_arg1_reg;
    logic             rsp_valid_reg [2];
    logic [31:0]      rsp_data_reg  [2];

    // -------------------------------------------------------------------------
    // Grant: the pointer only decides a tie; a lone valid requester always wins.
    // -------------------------------------------------------------------------
    logic grant;
    logic accept;
    logic done;

    always_comb begin
        grant = req_valid[1];
        if (&req_valid) begin
            grant = pri_reg;
        end
    end

    assign accept = (state_reg == IDLE) && (|req_valid);
    assign done   = (state_reg == EXEC) && (cnt_reg == '0);

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_ready
            assign req_ready[gi] = (state_reg == IDLE) && req_valid[gi] && (grant == 1'(gi));
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Latency decode
    // -------------------------------------------------------------------------
    function automatic logic is_mul(input logic [6:0] mode);
        return (mode == 7'b0000110) || (mode[6:2] == 5'b01010);
    endfunction

    logic [6:0]  sel_mode;
    logic [31:0] sel_arg0;
    logic [31:0] sel_arg1;

    assign sel_mode = req_mode[grant];
    assign sel_arg0 = req_arg0[grant];
    assign sel_arg1 = req_arg1[grant];

    // -------------------------------------------------------------------------
    // Scheduler FSM. The counter is loaded with L-1, so a one-cycle operation
    // completes in its first EXEC cycle.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            pri_reg      <= 1'b0;
            owner_reg    <= 1'b0;
            cnt_reg      <= '0;
            busy_reg     <= 1'b0;
            alu_mode_reg <= '0;
            alu_arg0_reg <= '0;
            alu_arg1_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        alu_mode_reg <= sel_mode;
                        alu_arg0_reg <= sel_arg0;
                        alu_arg1_reg <= sel_arg1;
                        owner_reg    <= grant;
                        pri_reg      <= ~grant;
                        cnt_reg      <= is_mul(sel_mode) ? MUL_CNT_LOAD : '0;
                        busy_reg     <= 1'b1;
                        state_reg    <= EXEC;
                    end
                end
                EXEC: begin
                    if (cnt_reg != '0) begin
                        cnt_reg <= cnt_reg - CNT_W'(1);
                    end else begin
                        busy_reg  <= 1'b0;
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Response registers. Only the owner's data is touched, so the other
    // requester's last result stays put.
    // -------------------------------------------------------------------------
    generate
        for (gi = 0; gi < 2; gi++) begin : g_rsp
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    rsp_valid_reg[gi] <= 1'b0;
                    rsp_data_reg[gi]  <= '0;
                end else begin
                    rsp_valid_reg[gi] <= done && (owner_reg == 1'(gi));
                    if (done && (owner_reg == 1'(gi))) begin
                        rsp_data_reg[gi] <= alu_ans;
                    end
                end
            end
        end
    endgenerate

    assign rsp0_valid = rsp_valid_reg[0];
    assign rsp0_data  = rsp_data_reg[0];
    assign rsp1_valid = rsp_valid_reg[1];
    assign rsp1_data  = rsp_data_reg[1];
    assign alu_mode   = alu_mode_reg;
    assign alu_arg0   = alu_arg0_reg;
    assign alu_arg1   = alu_arg1_reg;
    assign busy       = busy_reg;

endmodule
